run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_pkg.sv | 17 +
 rtl/run_ctrl_if.sv | 26 ++
 rtl/run_ctrl_halt_detector.sv | 48 ++++
 rtl/run_ctrl.sv | 100 ++++++++++
 tb/tb_run_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared state encoding and default parameter values for the run controller.
package run_ctrl_pkg;

    localparam int DEF_PC_W         = 16;
    localparam int DEF_RESET_CYCLES = 2;
    localparam int DEF_HALT_REPEAT  = 4;
    localparam int DEF_MAX_CYCLES   = 100000;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RST_HOLD = 3'd1,
        RUN      = 3'd2,
        HALTED   = 3'd3,
        TIMEOUT  = 3'd4
    } run_state_t;

endpackage

// File: rtl/run_ctrl_if.sv
// Host-side control/status bundle between a run controller and whoever drives it.
interface run_ctrl_if
    import run_ctrl_pkg::*;
#(
    parameter int PC_W = DEF_PC_W
);
    logic            start;
    logic            step_mode;
    logic            step;
    logic [PC_W-1:0] pc;
    logic            cpu_reset;
    logic            cpu_en;
    logic            ended;
    logic            timed_out;
    logic [31:0]     cycle_count;

    modport master (
        output start, step_mode, step, pc,
        input  cpu_reset, cpu_en, ended, timed_out, cycle_count
    );

    modport slave (
        input  start, step_mode, step, pc,
        output cpu_reset, cpu_en, ended, timed_out, cycle_count
    );
endinterface

// File: rtl/run_ctrl_halt_detector.sv
// Spots 1- and 2-instruction loops: counts consecutive executed PCs that repeat
// one of the previous two executed PCs; raises halt on the edge that completes the run.
module halt_detector
    import run_ctrl_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            en,
    input  logic [PC_W-1:0] pc,
    output logic            halt
);
    localparam int CNT_W = $clog2(HALT_REPEAT + 1);

    logic [PC_W-1:0]  h0, h1;
    logic             v0, v1;
    logic [CNT_W-1:0] match_cnt;
    logic             hit;

    assign hit  = (v0 && (pc == h0)) || (v1 && (pc == h1));
    assign halt = en && hit && (match_cnt == CNT_W'(HALT_REPEAT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h0        <= '0;
            h1        <= '0;
            v0        <= 1'b0;
            v1        <= 1'b0;
            match_cnt <= '0;
        end else if (clr) begin
            h0        <= '0;
            h1        <= '0;
            v0        <= 1'b0;
            v1        <= 1'b0;
            match_cnt <= '0;
        end else if (en) begin
            h0        <= pc;
            h1        <= h0;
            v0        <= 1'b1;
            v1        <= v0;
            // Any fresh PC breaks the streak; idle cycles leave it alone.
            match_cnt <= hit ? match_cnt + 1'b1 : '0;
        end
    end
endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds the CPU in reset after start, gates its clock-enable
// (free-run or single-step) and ends the run on a halt loop or an exhausted budget.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int PC_W         = DEF_PC_W,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int HALT_REPEAT  = DEF_HALT_REPEAT,
    parameter int MAX_CYCLES   = DEF_MAX_CYCLES
) (
    input logic       clk,
    input logic       reset,
    run_ctrl_if.slave bus
);
    localparam int RST_W = $clog2(RESET_CYCLES + 1);

    run_state_t       state;
    logic [RST_W-1:0] hold_cnt;
    logic             hold_cpu;
    logic             exec_en;
    logic             done;
    logic             budget_hit;
    logic [31:0]      cycles;
    logic             run_en;
    logic             exec;
    logic             halt;
    logic             last_budget;

    assign run_en      = !bus.step_mode || bus.step;
    assign exec        = (state == RUN) && exec_en;
    assign last_budget = exec && (cycles == 32'(MAX_CYCLES - 1));

    halt_detector #(
        .PC_W        (PC_W),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.start),
        .en    (exec),
        .pc    (bus.pc),
        .halt  (halt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            hold_cpu   <= 1'b1;
            exec_en    <= 1'b0;
            done       <= 1'b0;
            budget_hit <= 1'b0;
            cycles     <= '0;
        end else if (bus.start) begin
            // Start from any state (re)enters reset hold at its first cycle.
            state      <= RST_HOLD;
            hold_cnt   <= '0;
            hold_cpu   <= 1'b1;
            exec_en    <= 1'b0;
            done       <= 1'b0;
            budget_hit <= 1'b0;
            cycles     <= '0;
        end else begin
            case (state)
                RST_HOLD: begin
                    if (hold_cnt == RST_W'(RESET_CYCLES - 1)) begin
                        state    <= RUN;
                        hold_cpu <= 1'b0;
                        exec_en  <= run_en;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (exec) cycles <= cycles + 32'd1;
                    // A halt loop completing on the last budgeted cycle is still a halt.
                    if (halt) begin
                        state   <= HALTED;
                        done    <= 1'b1;
                        exec_en <= 1'b0;
                    end else if (last_budget) begin
                        state      <= TIMEOUT;
                        done       <= 1'b1;
                        budget_hit <= 1'b1;
                        exec_en    <= 1'b0;
                    end else begin
                        exec_en <= run_en;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cpu_reset   = hold_cpu;
    assign bus.cpu_en      = exec_en;
    assign bus.ended       = done;
    assign bus.timed_out   = budget_hit;
    assign bus.cycle_count = cycles;
endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: two instances (budgets 20 and 6) share one stimulus stream,
// checked against a list-level model of halt-loop and budget rules.
module tb_run_ctrl;
    localparam int HR    = 4;
    localparam int MAX_A = 20;
    localparam int MAX_B = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          errors = 0;
    int          pc_idx = 0;
    int          exec_b = 0;
    logic [15:0] prog[$];
    logic [3:0]  fa, fb;

    run_ctrl_if #(.PC_W(16)) bus_a ();
    run_ctrl_if #(.PC_W(16)) bus_b ();

    assign bus_b.start     = bus_a.start;
    assign bus_b.step_mode = bus_a.step_mode;
    assign bus_b.step      = bus_a.step;
    assign bus_b.pc        = bus_a.pc;

    // {ended, timed_out, cpu_en, cpu_reset}
    assign fa = {bus_a.ended, bus_a.timed_out, bus_a.cpu_en, bus_a.cpu_reset};
    assign fb = {bus_b.ended, bus_b.timed_out, bus_b.cpu_en, bus_b.cpu_reset};

    run_ctrl #(.PC_W(16), .RESET_CYCLES(2), .HALT_REPEAT(HR), .MAX_CYCLES(MAX_A)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    run_ctrl #(.PC_W(16), .RESET_CYCLES(2), .HALT_REPEAT(HR), .MAX_CYCLES(MAX_B)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    always #5 clk = ~clk;

    // Walk the executed-PC list: a repeat of either of the two previous executed
    // PCs extends the streak, anything else resets it; halt beats the budget.
    function automatic void model(input int max_c, output int n, output bit halted);
        int cnt;
        bit m;
        cnt = 0; n = 0; halted = 1'b0;
        for (int i = 0; i < prog.size(); i++) begin
            m = 1'b0;
            if (i >= 1 && prog[i] == prog[i-1]) m = 1'b1;
            if (i >= 2 && prog[i] == prog[i-2]) m = 1'b1;
            cnt = m ? cnt + 1 : 0;
            n = i + 1;
            if (cnt == HR) begin halted = 1'b1; return; end
            if (n == max_c) return;
        end
    endfunction

    task automatic start_run();
        pc_idx = 0; exec_b = 0;
        bus_a.step = 1'b0;
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
    endtask

    // CPU stand-in: pc advances after each edge on which cpu_en was high.
    task automatic drive_run(input bit noise, output int rc, output bit bound_hit);
        int cyc;
        bit ea, eb;
        cyc = 0; rc = 0;
        if (bus_a.cpu_reset) rc++;
        while (!bus_a.ended && cyc < 300) begin
            bus_a.pc = prog[pc_idx];
            if (noise) bus_a.step = 1'($urandom_range(0, 1));
            ea = bus_a.cpu_en; eb = bus_b.cpu_en;
            @(posedge clk); #1;
            if (ea) pc_idx++;
            if (eb) exec_b++;
            if (bus_a.cpu_reset) rc++;
            cyc++;
        end
        bus_a.step = 1'b0;
        bound_hit = (cyc >= 300);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (fa !== 4'b0001) begin errors++; $display("FAIL reset_flags_a: got %b want 0001", fa); end
        checks++; if (bus_a.cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count_a: got %0d want 0", bus_a.cycle_count); end
        checks++; if (fb !== 4'b0001) begin errors++; $display("FAIL reset_flags_b: got %b want 0001", fb); end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (fa !== 4'b0001) begin errors++; $display("FAIL idle_hold_a: got %b want 0001", fa); end
    endtask

    task automatic test_halt_loop();
        int rc; bit bh;
        logic [15:0] seq [12] = '{0, 1, 2, 3, 4, 5, 4, 5, 4, 5, 4, 5};
        prog.delete();
        for (int i = 0; i < 64; i++) prog.push_back(i < 12 ? seq[i] : 16'd5);
        start_run();
        drive_run(1'b0, rc, bh);
        checks++; if (bh) begin errors++; $display("FAIL halt_bound: got timeout want ended"); end
        checks++; if (rc !== 2) begin errors++; $display("FAIL halt_rst_cycles: got %0d want 2", rc); end
        checks++; if (fa !== 4'b1000) begin errors++; $display("FAIL halt_flags_a: got %b want 1000", fa); end
        checks++; if (bus_a.cycle_count !== 32'd10) begin errors++; $display("FAIL halt_count_a: got %0d want 10", bus_a.cycle_count); end
        checks++; if (pc_idx !== 10) begin errors++; $display("FAIL halt_execs_a: got %0d want 10", pc_idx); end
        checks++; if (fb !== 4'b1100) begin errors++; $display("FAIL halt_flags_b: got %b want 1100", fb); end
        checks++; if (bus_b.cycle_count !== 32'd6) begin errors++; $display("FAIL halt_count_b: got %0d want 6", bus_b.cycle_count); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_a.cycle_count !== 32'd10) begin errors++; $display("FAIL halt_frozen_a: got %0d want 10", bus_a.cycle_count); end
    endtask

    task automatic test_timeout();
        int rc; bit bh;
        prog.delete();
        for (int i = 0; i < 64; i++) prog.push_back(16'(i));
        start_run();
        drive_run(1'b0, rc, bh);
        checks++; if (bh) begin errors++; $display("FAIL to_bound: got timeout want ended"); end
        checks++; if (fa !== 4'b1100) begin errors++; $display("FAIL to_flags_a: got %b want 1100", fa); end
        checks++; if (bus_a.cycle_count !== 32'd20) begin errors++; $display("FAIL to_count_a: got %0d want 20", bus_a.cycle_count); end
        checks++; if (exec_b !== 6) begin errors++; $display("FAIL to_execs_b: got %0d want 6", exec_b); end
    endtask

    task automatic test_coincide();
        int rc; bit bh;
        // All zeros: streak completes on the 5th execution, inside both budgets.
        prog.delete();
        for (int i = 0; i < 64; i++) prog.push_back(16'd0);
        start_run(); drive_run(1'b0, rc, bh);
        checks++; if (fb !== 4'b1000) begin errors++; $display("FAIL zeros_flags_b: got %b want 1000", fb); end
        checks++; if (bus_b.cycle_count !== 32'd5) begin errors++; $display("FAIL zeros_count_b: got %0d want 5", bus_b.cycle_count); end
        // 0..15 then 15s: fourth match lands exactly on execution 20.
        prog.delete();
        for (int i = 0; i < 64; i++) prog.push_back(i < 16 ? 16'(i) : 16'd15);
        start_run(); drive_run(1'b0, rc, bh);
        checks++; if (fa !== 4'b1000) begin errors++; $display("FAIL coin_flags_a: got %b want 1000", fa); end
        checks++; if (bus_a.cycle_count !== 32'd20) begin errors++; $display("FAIL coin_count_a: got %0d want 20", bus_a.cycle_count); end
        checks++; if (fb !== 4'b1100) begin errors++; $display("FAIL coin_flags_b: got %b want 1100", fb); end
        // 0 then 1s: fourth match lands exactly on execution 6 of the small budget.
        prog.delete();
        for (int i = 0; i < 64; i++) prog.push_back(i == 0 ? 16'd0 : 16'd1);
        start_run(); drive_run(1'b0, rc, bh);
        checks++; if (fb !== 4'b1000) begin errors++; $display("FAIL coin6_flags_b: got %b want 1000", fb); end
        checks++; if (bus_b.cycle_count !== 32'd6) begin errors++; $display("FAIL coin6_count_b: got %0d want 6", bus_b.cycle_count); end
    endtask

    task automatic test_step();
        int pulses, bad, rc;
        bit ea, eb, want, bh;
        prog.delete();
        for (int i = 0; i < 64; i++) prog.push_back(16'(100 + i));
        bus_a.step_mode = 1'b1;
        start_run();
        for (int c = 0; c < 10 && bus_a.cpu_reset; c++) begin
            bus_a.pc = prog[pc_idx]; @(posedge clk); #1;
        end
        checks++; if (fa !== 4'b0000) begin errors++; $display("FAIL step_run_entry: got %b want 0000", fa); end
        pulses = 0; bad = 0;
        for (int i = 0; i < 14; i++) begin
            bus_a.pc = prog[pc_idx];
            bus_a.step = (i % 5 == 0);
            want = bus_a.step;
            ea = bus_a.cpu_en; eb = bus_b.cpu_en;
            @(posedge clk); #1;
            if (ea) pc_idx++;
            if (eb) exec_b++;
            if (bus_a.cpu_en) pulses++;
            if (bus_a.cpu_en !== want) bad++;
        end
        bus_a.step = 1'b0;
        checks++; if (pulses !== 3) begin errors++; $display("FAIL step_pulses: got %0d want 3", pulses); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL step_latency: got %0d want 0", bad); end
        checks++; if (bus_a.cycle_count !== 32'd3) begin errors++; $display("FAIL step_count_a: got %0d want 3", bus_a.cycle_count); end
        checks++; if (bus_b.cycle_count !== 32'd3) begin errors++; $display("FAIL step_count_b: got %0d want 3", bus_b.cycle_count); end
        bus_a.step_mode = 1'b0;
        drive_run(1'b1, rc, bh);
        checks++; if (fa !== 4'b1100 || bus_a.cycle_count !== 32'd20) begin errors++; $display("FAIL step_free_a: got %b/%0d want 1100/20", fa, bus_a.cycle_count); end
        checks++; if (pc_idx !== 20 || exec_b !== 6) begin errors++; $display("FAIL step_free_execs: got %0d/%0d want 20/6", pc_idx, exec_b); end
    endtask

    task automatic test_random();
        int na, nb, rc, alpha;
        bit ha, hb, bh;
        bus_a.step_mode = 1'b0;
        for (int it = 0; it < 10; it++) begin
            alpha = $urandom_range(1, 12);
            prog.delete();
            for (int i = 0; i < 64; i++) prog.push_back(16'($urandom_range(0, alpha)));
            model(MAX_A, na, ha);
            model(MAX_B, nb, hb);
            start_run(); drive_run(1'b1, rc, bh);
            checks++; if (bh || bus_a.ended !== 1'b1) begin errors++; $display("FAIL rnd%0d_ended: got %b want 1", it, bus_a.ended); end
            checks++; if (bus_a.cycle_count !== 32'(na) || pc_idx !== na) begin errors++; $display("FAIL rnd%0d_count_a: got %0d want %0d", it, bus_a.cycle_count, na); end
            checks++; if (bus_a.timed_out !== !ha) begin errors++; $display("FAIL rnd%0d_to_a: got %b want %b", it, bus_a.timed_out, !ha); end
            checks++; if (bus_b.cycle_count !== 32'(nb) || bus_b.timed_out !== !hb) begin errors++; $display("FAIL rnd%0d_b: got %0d/%b want %0d/%b", it, bus_b.cycle_count, bus_b.timed_out, nb, !hb); end
        end
    endtask

    task automatic test_reset_midrun();
        int na, nb, rc;
        bit ha, hb, bh, ea;
        prog.delete();
        for (int i = 0; i < 64; i++) prog.push_back(16'(i + 300));
        bus_a.step_mode = 1'b0;
        start_run();
        repeat (6) begin
            bus_a.pc = prog[pc_idx]; ea = bus_a.cpu_en;
            @(posedge clk); #1;
            if (ea) pc_idx++;
        end
        checks++; if (bus_a.cycle_count !== 32'd4) begin errors++; $display("FAIL mid_pre_count: got %0d want 4", bus_a.cycle_count); end
        #3 reset = 1'b1;
        #1;
        checks++; if (fa !== 4'b0001 || bus_a.cycle_count !== 32'd0) begin errors++; $display("FAIL mid_async_a: got %b/%0d want 0001/0", fa, bus_a.cycle_count); end
        checks++; if (fb !== 4'b0001 || bus_b.cycle_count !== 32'd0) begin errors++; $display("FAIL mid_async_b: got %b/%0d want 0001/0", fb, bus_b.cycle_count); end
        @(posedge clk); #4;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (fa !== 4'b0001) begin errors++; $display("FAIL mid_idle: got %b want 0001", fa); end
        for (int i = 0; i < 64; i++) prog[i] = 16'($urandom_range(0, 5));
        model(MAX_A, na, ha);
        model(MAX_B, nb, hb);
        start_run(); drive_run(1'b0, rc, bh);
        checks++; if (rc !== 2 || bus_a.cycle_count !== 32'(na) || bus_a.timed_out !== !ha) begin errors++; $display("FAIL mid_fresh_a: got %0d/%0d/%b want 2/%0d/%b", rc, bus_a.cycle_count, bus_a.timed_out, na, !ha); end
        checks++; if (bus_b.cycle_count !== 32'(nb)) begin errors++; $display("FAIL mid_fresh_b: got %0d want %0d", bus_b.cycle_count, nb); end
    endtask

    task automatic test_back_to_back();
        int rc;
        bit bh, ea;
        prog.delete();
        for (int i = 0; i < 64; i++) prog.push_back(16'd7);
        start_run(); drive_run(1'b0, rc, bh);
        checks++; if (fa !== 4'b1000 || bus_a.cycle_count !== 32'd5) begin errors++; $display("FAIL b2b_first: got %b/%0d want 1000/5", fa, bus_a.cycle_count); end
        // Restart from HALTED with an alternating pair: fourth match on execution 6.
        for (int i = 0; i < 64; i++) prog[i] = (i % 2 == 0) ? 16'd1 : 16'd2;
        start_run();
        checks++; if (fa !== 4'b0001 || bus_a.cycle_count !== 32'd0) begin errors++; $display("FAIL b2b_restart: got %b/%0d want 0001/0", fa, bus_a.cycle_count); end
        drive_run(1'b0, rc, bh);
        checks++; if (rc !== 2) begin errors++; $display("FAIL b2b_rst_cycles: got %0d want 2", rc); end
        checks++; if (fa !== 4'b1000 || bus_a.cycle_count !== 32'd6) begin errors++; $display("FAIL b2b_second: got %b/%0d want 1000/6", fa, bus_a.cycle_count); end
        // Abort a run in progress with another start.
        for (int i = 0; i < 64; i++) prog[i] = 16'(i + 50);
        start_run();
        repeat (5) begin
            bus_a.pc = prog[pc_idx]; ea = bus_a.cpu_en;
            @(posedge clk); #1;
            if (ea) pc_idx++;
        end
        start_run();
        checks++; if (fa !== 4'b0001 || bus_a.cycle_count !== 32'd0) begin errors++; $display("FAIL abort_restart: got %b/%0d want 0001/0", fa, bus_a.cycle_count); end
        drive_run(1'b0, rc, bh);
        checks++; if (rc !== 2 || fa !== 4'b1100 || bus_a.cycle_count !== 32'd20) begin errors++; $display("FAIL abort_run: got %0d/%b/%0d want 2/1100/20", rc, fa, bus_a.cycle_count); end
    endtask

    initial begin
        bus_a.start = 1'b0;
        bus_a.step_mode = 1'b0;
        bus_a.step = 1'b0;
        bus_a.pc = '0;
        test_reset();
        test_halt_loop();
        test_timeout();
        test_coincide();
        test_step();
        test_random();
        test_reset_midrun();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
